// File: rtl/board_ram_arbiter.sv
// Read/write arbiter for the 64x2 checkerboard state RAM: judger/scanner read
// arbitration with starvation guard, move-write buffering behind memory reset.
// Optional read-after-write bypass enabled by defining BOARD_ARB_RAW_BYPASS_EN.
module board_ram_arbiter #(
    parameter int ADDR_BITS    = 6,
    parameter int DATA_BITS    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 prio_judger,
    input  logic                 memrst_we,
    input  logic [ADDR_BITS-1:0] memrst_addr,
    input  logic [DATA_BITS-1:0] memrst_data,
    input  logic                 game_we,
    input  logic [ADDR_BITS-1:0] game_addr,
    input  logic [DATA_BITS-1:0] game_data,
    input  logic                 jdg_req,
    input  logic [ADDR_BITS-1:0] jdg_addr,
    output logic                 jdg_gnt,
    output logic                 jdg_rvalid,
    output logic [DATA_BITS-1:0] jdg_rdata,
    input  logic                 scn_req,
    input  logic [ADDR_BITS-1:0] scn_addr,
    output logic                 scn_gnt,
    output logic                 scn_rvalid,
    output logic [DATA_BITS-1:0] scn_rdata,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_wr_addr,
    output logic [DATA_BITS-1:0] ram_wr_data,
    output logic [ADDR_BITS-1:0] ram_rd_addr,
    input  logic [DATA_BITS-1:0] ram_rd_data,
    output logic                 wr_pending,
    output logic                 wr_overflow
);

    typedef enum logic {REQ_JDG = 1'b0, REQ_SCN = 1'b1} req_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    req_e                 rr_next;      // requester that wins the next round-robin tie
    logic [3:0]           starve_cnt;
    logic                 tag_valid;
    req_e                 tag_who;
    logic [ADDR_BITS-1:0] rd_addr_q;
    logic [DATA_BITS-1:0] jdg_rdata_q;
    logic [DATA_BITS-1:0] scn_rdata_q;
    logic [DATA_BITS-1:0] rd_value;

    logic                 buf_valid;
    logic [ADDR_BITS-1:0] buf_addr;
    logic [DATA_BITS-1:0] buf_data;
    logic                 overflow_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic [DATA_BITS-1:0] wr_data_q;

    logic                 rd_grant;
    logic [ADDR_BITS-1:0] grant_addr;
    logic                 buf_load;
    logic                 buf_drain;
    logic                 overflow_set;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        jdg_gnt = 1'b0;
        scn_gnt = 1'b0;
        if (jdg_req && scn_req) begin
            if (starve_cnt == STARVE_MAX)  scn_gnt = 1'b1;
            else if (prio_judger)          jdg_gnt = 1'b1;
            else if (rr_next == REQ_SCN)   scn_gnt = 1'b1;
            else                           jdg_gnt = 1'b1;
        end else begin
            jdg_gnt = jdg_req;
            scn_gnt = scn_req;
        end
    end

    assign rd_grant    = jdg_gnt | scn_gnt;
    assign grant_addr  = jdg_gnt ? jdg_addr : scn_addr;
    assign ram_rd_addr = rd_grant ? grant_addr : rd_addr_q;

    // Memory reset always owns the write port; the move buffer drains behind it.
    always_comb begin
        ram_we       = 1'b0;
        ram_wr_addr  = wr_addr_q;
        ram_wr_data  = wr_data_q;
        buf_load     = 1'b0;
        buf_drain    = 1'b0;
        overflow_set = 1'b0;
        if (memrst_we) begin
            ram_we      = 1'b1;
            ram_wr_addr = memrst_addr;
            ram_wr_data = memrst_data;
            if (game_we) begin
                if (buf_valid) overflow_set = 1'b1;
                else           buf_load     = 1'b1;
            end
        end else if (buf_valid) begin
            ram_we      = 1'b1;
            ram_wr_addr = buf_addr;
            ram_wr_data = buf_data;
            buf_drain   = 1'b1;
            buf_load    = game_we;
        end else if (game_we) begin
            ram_we      = 1'b1;
            ram_wr_addr = game_addr;
            ram_wr_data = game_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_next     <= REQ_JDG;
            starve_cnt  <= '0;
            tag_valid   <= 1'b0;
            tag_who     <= REQ_JDG;
            rd_addr_q   <= '0;
            jdg_rdata_q <= '0;
            scn_rdata_q <= '0;
            buf_valid   <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
            overflow_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            if (jdg_gnt)      rr_next <= REQ_SCN;
            else if (scn_gnt) rr_next <= REQ_JDG;

            if (scn_req && !scn_gnt) begin
                if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end

            tag_valid <= rd_grant;
            tag_who   <= scn_gnt ? REQ_SCN : REQ_JDG;
            if (rd_grant) rd_addr_q <= grant_addr;

            if (jdg_rvalid) jdg_rdata_q <= rd_value;
            if (scn_rvalid) scn_rdata_q <= rd_value;

            if (buf_load) begin
                buf_valid <= 1'b1;
                buf_addr  <= game_addr;
                buf_data  <= game_data;
            end else if (buf_drain) begin
                buf_valid <= 1'b0;
            end
            if (overflow_set) overflow_q <= 1'b1;

            if (ram_we) begin
                wr_addr_q <= ram_wr_addr;
                wr_data_q <= ram_wr_data;
            end
        end
    end

`ifdef BOARD_ARB_RAW_BYPASS_EN
    logic                 byp_hit;
    logic [DATA_BITS-1:0] byp_data;

    // The RAM returns the old value on a same-address read/write; forward the new one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_hit  <= rd_grant && ram_we && (ram_wr_addr == grant_addr);
            byp_data <= ram_wr_data;
        end
    end

    assign rd_value = byp_hit ? byp_data : ram_rd_data;
`else
    assign rd_value = ram_rd_data;
`endif

    assign jdg_rvalid  = tag_valid && (tag_who == REQ_JDG);
    assign scn_rvalid  = tag_valid && (tag_who == REQ_SCN);
    assign jdg_rdata   = jdg_rvalid ? rd_value : jdg_rdata_q;
    assign scn_rdata   = scn_rvalid ? rd_value : scn_rdata_q;
    assign wr_pending  = buf_valid;
    assign wr_overflow = overflow_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed, table-driven bench for board_ram_arbiter with a behavioural
// read-before-write RAM; also covers reset mid-read and the starvation guard.
module tb_board_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prio_judger;
    logic       memrst_we;
    logic [5:0] memrst_addr;
    logic [1:0] memrst_data;
    logic       game_we;
    logic [5:0] game_addr;
    logic [1:0] game_data;
    logic       jdg_req;
    logic [5:0] jdg_addr;
    logic       jdg_gnt;
    logic       jdg_rvalid;
    logic [1:0] jdg_rdata;
    logic       scn_req;
    logic [5:0] scn_addr;
    logic       scn_gnt;
    logic       scn_rvalid;
    logic [1:0] scn_rdata;
    logic       ram_we;
    logic [5:0] ram_wr_addr;
    logic [1:0] ram_wr_data;
    logic [5:0] ram_rd_addr;
    logic [1:0] ram_rd_data;
    logic       wr_pending;
    logic       wr_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    board_ram_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prio_judger (prio_judger),
        .memrst_we   (memrst_we),
        .memrst_addr (memrst_addr),
        .memrst_data (memrst_data),
        .game_we     (game_we),
        .game_addr   (game_addr),
        .game_data   (game_data),
        .jdg_req     (jdg_req),
        .jdg_addr    (jdg_addr),
        .jdg_gnt     (jdg_gnt),
        .jdg_rvalid  (jdg_rvalid),
        .jdg_rdata   (jdg_rdata),
        .scn_req     (scn_req),
        .scn_addr    (scn_addr),
        .scn_gnt     (scn_gnt),
        .scn_rvalid  (scn_rvalid),
        .scn_rdata   (scn_rdata),
        .ram_we      (ram_we),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .wr_pending  (wr_pending),
        .wr_overflow (wr_overflow)
    );

    // Synchronous RAM, read-before-write on an address collision.
    logic [1:0] mem [64];
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    typedef struct {
        int prio, mr_we, mr_addr, mr_data, g_we, g_addr, g_data, j_req, j_addr, s_req, s_addr;
        int e_jgnt, e_sgnt, e_jrv, e_jrd, e_srv, e_srd, e_we, e_waddr, e_wdata, e_rdaddr, e_pend, e_ovf;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

`ifdef BOARD_ARB_RAW_BYPASS_EN
    localparam int RAW_DATA = 2;
`else
    localparam int RAW_DATA = 0;
`endif

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        prio_judger = v.prio[0];
        memrst_we   = v.mr_we[0];
        memrst_addr = 6'(v.mr_addr);
        memrst_data = 2'(v.mr_data);
        game_we     = v.g_we[0];
        game_addr   = 6'(v.g_addr);
        game_data   = 2'(v.g_data);
        jdg_req     = v.j_req[0];
        jdg_addr    = 6'(v.j_addr);
        scn_req     = v.s_req[0];
        scn_addr    = 6'(v.s_addr);
    endtask

    task automatic idle_inputs();
        prio_judger = 1'b0;
        memrst_we   = 1'b0;
        memrst_addr = '0;
        memrst_data = '0;
        game_we     = 1'b0;
        game_addr   = '0;
        game_data   = '0;
        jdg_req     = 1'b0;
        jdg_addr    = '0;
        scn_req     = 1'b0;
        scn_addr    = '0;
    endtask

    initial begin
        //          prio mrwe mra mrd gwe ga gd jr ja sr sa | jg sg jv jd sv sd we wa wd rda pend ovf
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 1, 0, 0, 0, 0, 0, 9, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20,   0, 1, 0, 1, 0, 0, 0, 0, 0, 20, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1, 2, 0, 0, 0, 20, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 33, 1, 40,  1, 0, 0, 1, 0, 2, 0, 0, 0, 33, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 33, 1, 40,  0, 1, 1, 1, 0, 2, 0, 0, 0, 40, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 33, 1, 40,  1, 0, 0, 1, 1, 2, 0, 0, 0, 33, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 33, 1, 40,  0, 1, 1, 1, 0, 2, 0, 0, 0, 40, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 1, 2, 0, 0, 0, 40, 0, 0};
        vecs[10] = '{0, 1, 1, 1, 1, 12, 2, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2, 1, 1, 1, 40, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2, 1, 12, 2, 40, 1, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2, 0, 0, 0, 40, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 1, 7, 1, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2, 1, 7, 1, 40, 0, 0};
        vecs[14] = '{0, 1, 2, 0, 1, 13, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2, 1, 2, 0, 40, 0, 0};
        vecs[15] = '{0, 0, 0, 0, 1, 14, 2, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2, 1, 13, 1, 40, 1, 0};
        vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2, 1, 14, 2, 40, 1, 0};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2, 0, 0, 0, 40, 0, 0};
        vecs[18] = '{0, 1, 3, 1, 1, 15, 2, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2, 1, 3, 1, 40, 0, 0};
        vecs[19] = '{0, 1, 4, 2, 1, 16, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2, 1, 4, 2, 40, 1, 0};
        vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2, 1, 15, 2, 40, 1, 1};
        vecs[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 2, 0, 0, 0, 40, 0, 1};
        vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0,   1, 0, 0, 1, 0, 2, 0, 0, 0, 12, 0, 1};
        vecs[23] = '{0, 0, 0, 0, 0, 0, 0, 1, 15, 0, 0,   1, 0, 1, 2, 0, 2, 0, 0, 0, 15, 0, 1};
        vecs[24] = '{0, 0, 0, 0, 0, 0, 0, 1, 16, 0, 0,   1, 0, 1, 2, 0, 2, 0, 0, 0, 16, 0, 1};
        vecs[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 0, 0, 2, 0, 0, 0, 16, 0, 1};
        vecs[26] = '{0, 0, 0, 0, 1, 5, 2, 1, 5, 0, 0,    1, 0, 0, 0, 0, 2, 1, 5, 2, 5, 0, 1};
        vecs[27] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 1, RAW_DATA, 0, 2, 0, 0, 0, 5, 0, 1};

        for (int a = 0; a < 64; a++) mem[a] = 2'b00;
        mem[9]  = 2'b01;
        mem[20] = 2'b10;
        mem[33] = 2'b01;
        mem[40] = 2'b10;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check($sformatf("v%0d jdg_gnt", i),     8'(jdg_gnt),     8'(vecs[i].e_jgnt));
            check($sformatf("v%0d scn_gnt", i),     8'(scn_gnt),     8'(vecs[i].e_sgnt));
            check($sformatf("v%0d jdg_rvalid", i),  8'(jdg_rvalid),  8'(vecs[i].e_jrv));
            check($sformatf("v%0d jdg_rdata", i),   8'(jdg_rdata),   8'(vecs[i].e_jrd));
            check($sformatf("v%0d scn_rvalid", i),  8'(scn_rvalid),  8'(vecs[i].e_srv));
            check($sformatf("v%0d scn_rdata", i),   8'(scn_rdata),   8'(vecs[i].e_srd));
            check($sformatf("v%0d ram_we", i),      8'(ram_we),      8'(vecs[i].e_we));
            if (vecs[i].e_we != 0) begin
                check($sformatf("v%0d ram_wr_addr", i), 8'(ram_wr_addr), 8'(vecs[i].e_waddr));
                check($sformatf("v%0d ram_wr_data", i), 8'(ram_wr_data), 8'(vecs[i].e_wdata));
            end
            check($sformatf("v%0d ram_rd_addr", i), 8'(ram_rd_addr), 8'(vecs[i].e_rdaddr));
            check($sformatf("v%0d wr_pending", i),  8'(wr_pending),  8'(vecs[i].e_pend));
            check($sformatf("v%0d wr_overflow", i), 8'(wr_overflow), 8'(vecs[i].e_ovf));
            @(posedge clk);
            #1;
        end

        // Reset lands while a judger read is in flight: no rvalid may follow,
        // and the sticky overflow flag clears.
        jdg_req  = 1'b1;
        jdg_addr = 6'd9;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst jdg_rvalid", 8'(jdg_rvalid), 8'd0);
        check("rst jdg_rdata",  8'(jdg_rdata),  8'd0);
        check("rst scn_rdata",  8'(scn_rdata),  8'd0);
        check("rst wr_overflow", 8'(wr_overflow), 8'd0);
        check("rst wr_pending",  8'(wr_pending),  8'd0);
        @(posedge clk);
        #1;

        // Judger priority with both requesting: eight judger grants, then a
        // forced scanner grant, repeating every nine cycles.
        prio_judger = 1'b1;
        jdg_req     = 1'b1;
        jdg_addr    = 6'd33;
        scn_req     = 1'b1;
        scn_addr    = 6'd40;
        for (int c = 0; c < 20; c++) begin
            logic exp_s;
            logic prev_s;
            exp_s  = (c % 9) == 8;
            prev_s = (c >= 1) && (((c - 1) % 9) == 8);
            @(negedge clk);
            check($sformatf("starve c%0d scn_gnt", c), 8'(scn_gnt), 8'(exp_s));
            check($sformatf("starve c%0d jdg_gnt", c), 8'(jdg_gnt), 8'(!exp_s));
            check($sformatf("starve c%0d scn_rvalid", c), 8'(scn_rvalid), 8'(prev_s));
            check($sformatf("starve c%0d jdg_rvalid", c), 8'(jdg_rvalid), 8'((c >= 1) && !prev_s));
            if (c >= 1 && prev_s)
                check($sformatf("starve c%0d scn_rdata", c), 8'(scn_rdata), 8'd2);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(negedge clk);
        check("post jdg_rvalid", 8'(jdg_rvalid), 8'd1);
        check("post jdg_rdata",  8'(jdg_rdata),  8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
- Owns the single-read/single-write checkerboard state RAM (64 x 2-bit, 1-cycle synchronous read).
- Arbitrates the read port between the game judger and the LED scanner.
- Merges the memory-reset writer and the game move writer onto the one write port.
- Buffers a blocked move write, prevents scanner starvation while the judger has priority, and returns read data tagged to the requester.

Parameters:
- ADDR_BITS, 6, RAM address width (8x8 board).
- DATA_BITS, 2, cell width (00 empty, 01 red, 10 green).
- STARVE_LIMIT, 8, consecutive scanner denials before forced scanner grant; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- prio_judger  in  1  1 = judger fixed priority (game in judge state); 0 = round-robin.
- memrst_we  in  1  memory-reset write strobe.
- memrst_addr  in  ADDR_BITS  memory-reset write address.
- memrst_data  in  DATA_BITS  memory-reset write data.
- game_we  in  1  move write strobe, single-cycle pulse.
- game_addr  in  ADDR_BITS  move address.
- game_data  in  DATA_BITS  move colour.
- jdg_req  in  1  judger read request.
- jdg_addr  in  ADDR_BITS  judger read address.
- jdg_gnt  out  1  judger granted this cycle.
- jdg_rvalid  out  1  judger read data valid.
- jdg_rdata  out  DATA_BITS  judger read data.
- scn_req  in  1  scanner read request.
- scn_addr  in  ADDR_BITS  scanner read address.
- scn_gnt  out  1  scanner granted this cycle.
- scn_rvalid  out  1  scanner read data valid.
- scn_rdata  out  DATA_BITS  scanner read data.
- ram_we  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_BITS  RAM write address.
- ram_wr_data  out  DATA_BITS  RAM write data.
- ram_rd_addr  out  ADDR_BITS  RAM read address.
- ram_rd_data  in  DATA_BITS  RAM read data; valid 1 cycle after its address.
- wr_pending  out  1  move write held in the buffer.
- wr_overflow  out  1  sticky: a move write was lost.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all registered state clears.
  - rvalids=0, rdatas=0, wr_pending=0, wr_overflow=0.
  - Round-robin pointer points to judger (judger wins first tie).
  - Starvation counter=0.
  - Reset mid-read drops the in-flight tag; no rvalid follows.
- Read arbitration (combinational grant, same cycle as req):
  - Only one requesting: it is granted.
  - Both requesting, forced: starve counter == STARVE_LIMIT -> scanner granted.
  - Both requesting, prio_judger=1 -> judger granted.
  - Both requesting, otherwise -> requester not granted last time wins (pointer updates on every grant).
  - ram_rd_addr = granted requester's addr; with no grant it holds its last value.
- Starvation counter:
  - Increments when scn_req=1 and scn_gnt=0.
  - Clears on scn_gnt or scn_req=0.
  - Saturates at STARVE_LIMIT.
- Read return:
  - Registered tag {valid, who}. xx_rvalid pulses exactly 1 cycle after xx_gnt.
  - xx_rdata = ram_rd_data in that cycle, and holds until the next rvalid for that requester.
  - Back-to-back grants give back-to-back rvalids; throughput is 1 read/cycle.
- Write merge (memrst has absolute priority):
  - memrst_we=1 -> RAM write from memrst. A simultaneous game_we is captured into the buffer and wr_pending=1.
  - memrst_we=0, buffer full -> buffer drains to RAM; wr_pending clears next cycle. A simultaneous new game_we is captured in the same cycle (buffer stays full).
  - memrst_we=0, buffer empty, game_we=1 -> direct write, 0-cycle latency.
  - game_we while buffer full and memrst_we=1 -> new write dropped, wr_overflow=1 (sticky until rst_n).
- ram_we is combinational. ram_wr_addr/ram_wr_data are don't-care when ram_we=0 but must be driven (hold last).

Optional Feature:
- Macro BOARD_ARB_RAW_BYPASS_EN.
- Defined: the arbiter registers the write (we, addr, data) of each grant cycle. If a read was granted in the same cycle as a RAM write to the same address, the rdata at rvalid is the written data instead of ram_rd_data.
- Not defined: rdata = ram_rd_data unconditionally (RAM read-before-write, old value returned). The bypass comparator is absent.

Test Plan:
- Reset, then jdg_req only, addr 6'd9, RAM[9]=2'b01 -> jdg_gnt same cycle, jdg_rvalid next cycle with jdg_rdata=01; scn_rvalid stays 0.
- Both req held 4 cycles, prio_judger=0 -> grants alternate J,S,J,S; rvalids alternate one cycle later.
- prio_judger=1, both req held 20 cycles, STARVE_LIMIT=8 -> judger granted 8 cycles, scanner on 9th, pattern repeats every 9 cycles.
- memrst_we and game_we (addr 12, data 10) same cycle -> ram_we from memrst; wr_pending=1; next cycle with memrst_we=0, RAM writes addr 12 data 10 and wr_pending=0 after.
- Buffer full, memrst_we=1, second game_we -> wr_overflow=1 and stays 1 until rst_n=0; first buffered write still reaches RAM.
- With BOARD_ARB_RAW_BYPASS_EN: game write addr 5 data 10 and judger read addr 5 same cycle, RAM old 00 -> jdg_rdata=10; without the macro -> 00.
